// File: rtl/cell_operand_sequencer.sv
// Operand bank and two-state micro-op sequencer feeding the 8-input arithmetic/logic cell.
// Drives the cell's selects from registered controls and writes the cell result back into the bank.
module cell_operand_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [1:0]       instr_op,
    input  logic             instr_bypass,
    input  logic [2:0]       instr_src0,
    input  logic [2:0]       instr_src1,
    input  logic [2:0]       instr_dst,
    input  logic             load_en,
    input  logic [2:0]       load_addr,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] reg0,
    output logic [WIDTH-1:0] reg1,
    output logic [WIDTH-1:0] reg2,
    output logic [WIDTH-1:0] reg3,
    output logic [WIDTH-1:0] reg4,
    output logic [WIDTH-1:0] reg5,
    output logic [WIDTH-1:0] reg6,
    output logic [WIDTH-1:0] reg7,
    output logic [2:0]       sel0,
    output logic [2:0]       sel1,
    output logic [1:0]       selOp,
    output logic             byPass,
    input  logic [WIDTH-1:0] result,
    output logic             done,
    output logic [WIDTH-1:0] done_data,
    output logic [15:0]      instr_count
);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] regs [8];
    logic [2:0]       dst;

    assign instr_ready = (state == IDLE);

    assign reg0 = regs[0];
    assign reg1 = regs[1];
    assign reg2 = regs[2];
    assign reg3 = regs[3];
    assign reg4 = regs[4];
    assign reg5 = regs[5];
    assign reg6 = regs[6];
    assign reg7 = regs[7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            regs        <= '{default: '0};
            dst         <= '0;
            sel0        <= '0;
            sel1        <= '0;
            selOp       <= '0;
            byPass      <= 1'b1;
            done        <= 1'b0;
            done_data   <= '0;
            instr_count <= '0;
        end else begin
            done <= 1'b0;

            // Writeback below is the later assignment, so it overrides a load to the same index.
            if (load_en) begin
                regs[load_addr] <= load_data;
            end

            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        sel0   <= instr_src0;
                        sel1   <= instr_src1;
                        selOp  <= instr_op;
                        byPass <= instr_bypass;
                        dst    <= instr_dst;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    regs[dst] <= result;
                    done      <= 1'b1;
                    done_data <= result;
                    if (instr_count != 16'hFFFF) begin
                        instr_count <= instr_count + 16'd1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cell_operand_sequencer.sv
// Bench for cell_operand_sequencer: models the downstream cell, runs directed vectors,
// multi-cycle corner sequences and random instructions against an array-based reference.
module tb_cell_operand_sequencer;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [1:0]  instr_op;
    logic        instr_bypass;
    logic [2:0]  instr_src0;
    logic [2:0]  instr_src1;
    logic [2:0]  instr_dst;
    logic        load_en;
    logic [2:0]  load_addr;
    logic [31:0] load_data;
    logic [31:0] reg0, reg1, reg2, reg3, reg4, reg5, reg6, reg7;
    logic [2:0]  sel0;
    logic [2:0]  sel1;
    logic [1:0]  selOp;
    logic        byPass;
    logic [31:0] result;
    logic        done;
    logic [31:0] done_data;
    logic [15:0] instr_count;

    cell_operand_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_bypass(instr_bypass),
        .instr_src0(instr_src0), .instr_src1(instr_src1), .instr_dst(instr_dst),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .reg0(reg0), .reg1(reg1), .reg2(reg2), .reg3(reg3),
        .reg4(reg4), .reg5(reg5), .reg6(reg6), .reg7(reg7),
        .sel0(sel0), .sel1(sel1), .selOp(selOp), .byPass(byPass),
        .result(result),
        .done(done), .done_data(done_data), .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operation semantics of the cell; used both for the cell stand-in and for predictions.
    function automatic logic [31:0] cell_fn(input logic [1:0] op, input logic byp,
                                            input logic [31:0] a, input logic [31:0] b);
        if (byp) return a;
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return ~(a & b);
            default: return ~(a | b);
        endcase
    endfunction

    logic [31:0] r [8];
    assign r[0] = reg0;
    assign r[1] = reg1;
    assign r[2] = reg2;
    assign r[3] = reg3;
    assign r[4] = reg4;
    assign r[5] = reg5;
    assign r[6] = reg6;
    assign r[7] = reg7;

    always_comb result = cell_fn(selOp, byPass, r[sel0], r[sel1]);

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [8];
    logic [15:0] m_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_r%0d", tag, i), r[i], m_regs[i]);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_count = '0;
    endtask

    task automatic do_load(input logic [2:0] a, input logic [31:0] v);
        load_en = 1'b1; load_addr = a; load_data = v;
        tick();
        load_en = 1'b0;
        m_regs[a] = v;
    endtask

    // Full instruction: accept, execute (optional concurrent load), check done pulse width.
    task automatic issue(input string tag, input logic [1:0] op, input logic byp,
                         input logic [2:0] s0, input logic [2:0] s1, input logic [2:0] d,
                         input logic ld, input logic [2:0] la, input logic [31:0] lv);
        int waits;
        logic [31:0] res;
        waits = 0;
        while (!instr_ready && waits < 10) begin
            tick();
            waits++;
        end
        if (!instr_ready) check({tag, "_ready_timeout"}, 32'(instr_ready), 32'd1);
        instr_op = op; instr_bypass = byp; instr_src0 = s0; instr_src1 = s1; instr_dst = d;
        instr_valid = 1'b1;
        res = cell_fn(op, byp, m_regs[s0], m_regs[s1]);
        tick();
        instr_valid = 1'b0;
        check({tag, "_ready_exec"}, 32'(instr_ready), 32'd0);
        check({tag, "_done_exec"}, 32'(done), 32'd0);
        check({tag, "_ctrl"}, {23'd0, byPass, selOp, sel1, sel0}, {23'd0, byp, op, s1, s0});
        load_en = ld; load_addr = la; load_data = lv;
        tick();
        load_en = 1'b0;
        if (ld) m_regs[la] = lv;
        m_regs[d] = res;
        if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_done_data"}, done_data, res);
        check({tag, "_ready_back"}, 32'(instr_ready), 32'd1);
        check({tag, "_count"}, 32'(instr_count), 32'(m_count));
        check_regs(tag);
        tick();
        check({tag, "_done_low"}, 32'(done), 32'd0);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic        byp;
        logic [2:0]  s0;
        logic [2:0]  s1;
        logic [2:0]  d;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        int pulses;
        logic [3:0] rdy_seen;

        vecs[0] = '{op: 2'd0, byp: 1'b0, s0: 3'd1, s1: 3'd2, d: 3'd3, exp: 32'd8};
        vecs[1] = '{op: 2'd1, byp: 1'b0, s0: 3'd2, s1: 3'd1, d: 3'd4, exp: 32'hFFFF_FFFE};
        vecs[2] = '{op: 2'd2, byp: 1'b0, s0: 3'd1, s1: 3'd1, d: 3'd5, exp: 32'hFFFF_FFFA};
        vecs[3] = '{op: 2'd3, byp: 1'b0, s0: 3'd0, s1: 3'd0, d: 3'd6, exp: 32'hFFFF_FFFF};
        vecs[4] = '{op: 2'd2, byp: 1'b1, s0: 3'd3, s1: 3'd5, d: 3'd7, exp: 32'd8};

        rst_n = 1'b0; instr_valid = 1'b0; instr_op = '0; instr_bypass = 1'b0;
        instr_src0 = '0; instr_src1 = '0; instr_dst = '0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        model_reset();
        tick();
        tick();
        check("rst_ready", 32'(instr_ready), 32'd1);
        check("rst_bypass", 32'(byPass), 32'd1);
        check("rst_ctrl", {24'd0, selOp, sel1, sel0}, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_done_data", done_data, 32'd0);
        check("rst_count", 32'(instr_count), 32'd0);
        check_regs("rst");
        rst_n = 1'b1;
        tick();

        do_load(3'd1, 32'd5);
        do_load(3'd2, 32'd3);
        for (int i = 0; i < 5; i++) begin
            issue($sformatf("vec%0d", i), vecs[i].op, vecs[i].byp, vecs[i].s0,
                  vecs[i].s1, vecs[i].d, 1'b0, 3'd0, 32'd0);
            check($sformatf("vec%0d_table", i), r[vecs[i].d], vecs[i].exp);
        end

        // valid held for four cycles: expect two acceptances and ready 1,0,1,0
        instr_op = 2'd1; instr_bypass = 1'b1; instr_src0 = 3'd3; instr_src1 = 3'd4; instr_dst = 3'd7;
        instr_valid = 1'b1;
        acc = 0; pulses = 0;
        for (int c = 0; c < 4; c++) begin
            rdy_seen[3 - c] = instr_ready;
            if (instr_ready) acc++;
            tick();
            if (done) pulses++;
        end
        instr_valid = 1'b0;
        m_regs[7] = m_regs[3];
        m_count = m_count + 16'd2;
        check("hold_ready_seq", 32'(rdy_seen), 32'hA);
        check("hold_accepts", 32'(acc), 32'd2);
        check("hold_pulses", 32'(pulses), 32'd2);
        check("hold_count", 32'(instr_count), 32'(m_count));
        check_regs("hold");
        tick();

        // load collides with writeback index, then load to a source index during EXEC
        issue("ld_same", 2'd0, 1'b0, 3'd1, 3'd3, 3'd2, 1'b1, 3'd2, 32'h0000_DEAD);
        check("ld_same_r2", r[2], 32'd13);
        issue("ld_diff", 2'd0, 1'b0, 3'd0, 3'd1, 3'd2, 1'b1, 3'd0, 32'h11);
        check("ld_diff_r0", r[0], 32'h11);
        check("ld_diff_r2", r[2], 32'd5);

        // reset asserted in the middle of EXEC
        instr_op = 2'd0; instr_bypass = 1'b0; instr_src0 = 3'd1; instr_src1 = 3'd1; instr_dst = 3'd6;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        check("mid_in_exec", 32'(instr_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_ready", 32'(instr_ready), 32'd1);
        check("mid_bypass", 32'(byPass), 32'd1);
        check("mid_done", 32'(done), 32'd0);
        check("mid_count", 32'(instr_count), 32'd0);
        check_regs("mid");
        tick();
        check("mid_done_after", 32'(done), 32'd0);
        check("mid_r6_after", r[6], 32'd0);
        rst_n = 1'b1;
        tick();

        // random traffic
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0)
                do_load(3'($urandom_range(0, 7)), $urandom);
            issue($sformatf("rnd%0d", n), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom);
        end

        // saturation of the completion counter
        force dut.instr_count = 16'hFFFD;
        #1;
        release dut.instr_count;
        m_count = 16'hFFFD;
        for (int n = 0; n < 3; n++) begin
            issue($sformatf("sat%0d", n), 2'd0, 1'b0, 3'd1, 3'd2, 3'd3, 1'b0, 3'd0, 32'd0);
        end
        check("sat_final", 32'(instr_count), 32'h0000_FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
